// File: rtl/mealy_seq_detect_param.sv
// mealy_seq_detect_param
// Parametrised Mealy serial sequence detector on a 1-bit stream. The pattern
// (N bits, MSB received first) is fixed by parameters. On a mismatch the
// detector falls back to the longest pattern prefix that is still alive,
// using a KMP-style table computed at elaboration.
//
// Optional feature: define MEALY_MATCH_CNT_EN to build a saturating match
// counter on match_count. Without it, match_count is tied to zero and the
// port list is unchanged.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   x            serial data bit, used only when en=1
//   en           bit-valid qualifier
//   overlap      1 = overlapping detection, 0 = non-overlapping (sampled on match)
//   y            Mealy match flag, combinational from state, x and en
//   state_o      current matched-prefix length
//   match_count  saturating match count (zero unless MEALY_MATCH_CNT_EN)
//
// State table (S = matched-prefix length)
//   S     | meaning
//   0     | no pattern bits matched
//   k     | first k pattern bits matched (1 <= k <= N-2)
//   N-1   | all but the last bit matched; y asserts if x completes the pattern

module mealy_seq_detect_param #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1001,
   parameter int             CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  x,
   input  logic                  en,
   input  logic                  overlap,
   output logic                  y,
   output logic [$clog2(N)-1:0]  state_o,
   output logic [CNT_W-1:0]      match_count
);

   localparam int SW  = $clog2(N);
   localparam int TBL = 2 ** (SW + 1);

   if ((N < 2) || (N > 16)) begin : g_bad_n
      $error("mealy_seq_detect_param: N must be within 2..16");
   end

   // Longest proper pattern prefix that is a suffix of (first s pattern bits
   // followed by b). Capping k at N-1 keeps the result a legal state and,
   // for s=N-1 with a completing bit, yields the overlap restart point.
   function automatic int next_prefix(input int s, input logic b);
      int           best;
      int           idx;
      logic         ok;
      logic         bit_v;
      logic [N-1:0] pv;
      logic [N-1:0] pp;
      best = 0;
      for (int k = 1; k < N; k++) begin
         if (k <= s + 1) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
               idx = s + 1 - k + i;
               pv  = PATTERN >> (N - 1 - idx);
               pp  = PATTERN >> (N - 1 - i);
               bit_v = (idx == s) ? b : pv[0];
               if (bit_v != pp[0]) ok = 1'b0;
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   localparam int              F_N     = next_prefix(N - 1, PATTERN[0]);
   localparam logic [SW-1:0]   S_LAST  = SW'(N - 1);
   localparam logic [SW-1:0]   S_OVL   = SW'(F_N);

   // Next-state table indexed by {S, x}; codes >= N are unreachable.
   logic [SW-1:0] nxt_tbl [TBL];

   for (genvar gs = 0; gs < 2 ** SW; gs++) begin : g_s
      for (genvar gb = 0; gb < 2; gb++) begin : g_b
         if (gs < N) begin : g_live
            assign nxt_tbl[gs*2+gb] = SW'(next_prefix(gs, 1'(gb)));
         end else begin : g_dead
            assign nxt_tbl[gs*2+gb] = '0;
         end
      end
   end

   logic [SW-1:0] s_q;
   logic [SW-1:0] s_d;

   always_comb begin
      y   = en & (s_q == S_LAST) & (x == PATTERN[0]);
      s_d = s_q;
      if (en) begin
         if (y) begin
            s_d = overlap ? S_OVL : '0;
         end else begin
            s_d = nxt_tbl[{s_q, x}];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   assign state_o = s_q;

`ifdef MEALY_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (y && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`else
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detect_param.sv
module tb_mealy_seq_detect_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       x_a, en_a, ov_a, y_a;
   logic [1:0] st_a;
   logic [1:0] mc_a;
   logic       x_b, en_b, ov_b, y_b;
   logic [1:0] st_b;
   logic [7:0] mc_b;

   mealy_seq_detect_param #(.N(4), .PATTERN(4'b1001), .CNT_W(2)) dut_a (
      .clk(clk), .reset(reset), .x(x_a), .en(en_a), .overlap(ov_a),
      .y(y_a), .state_o(st_a), .match_count(mc_a)
   );

   mealy_seq_detect_param #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .x(x_b), .en(en_b), .overlap(ov_b),
      .y(y_b), .state_o(st_b), .match_count(mc_b)
   );

   typedef struct {
      logic       y;
      logic [1:0] s;
      logic [1:0] c;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int checks   = 0;
   int failures = 0;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en_a  = 1'b0;
      en_b  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      x_a = 1'b1; en_a = 1'b1; ov_a = 1'b0;
      x_b = 1'b1; en_b = 1'b1; ov_b = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (y_a !== 1'b0) begin failures++; $display("FAIL rst_y_a got=%b exp=0", y_a); end
      checks++; if (st_a !== 2'd0) begin failures++; $display("FAIL rst_state_a got=%0d exp=0", st_a); end
      checks++; if (mc_a !== 2'd0) begin failures++; $display("FAIL rst_count_a got=%0d exp=0", mc_a); end
      checks++; if (y_b !== 1'b0) begin failures++; $display("FAIL rst_y_b got=%b exp=0", y_b); end
      checks++; if (st_b !== 2'd0) begin failures++; $display("FAIL rst_state_b got=%0d exp=0", st_b); end
      checks++; if (mc_b !== 8'd0) begin failures++; $display("FAIL rst_count_b got=%0d exp=0", mc_b); end
      reset = 1'b0;
   endtask

   // Pattern 1001 stream 1001001: non-overlap and overlap
   task automatic test_overlap_modes();
      logic [6:0] xs    = 7'b1001001;
      logic [6:0] ys_n  = 7'b0001000;
      logic [6:0] ys_o  = 7'b0001001;
      int         st_n [7] = '{1, 2, 3, 0, 0, 0, 1};
      int         st_o [7] = '{1, 2, 3, 1, 2, 3, 1};
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         ov_a = (pass == 1);
         for (int i = 0; i < 7; i++) begin
            x_a  = xs[6-i];
            en_a = 1'b1;
            if (pass == 0) sb.push_back('{ys_n[6-i], 2'(st_n[i]), 2'd0});
            else           sb.push_back('{ys_o[6-i], 2'(st_o[i]), 2'd0});
            #2;
            e = sb.pop_front();
            checks++;
            if (y_a !== e.y) begin
               failures++; $display("FAIL ovl%0d_y bit%0d got=%b exp=%b", pass, i+1, y_a, e.y);
            end
            @(posedge clk); #1;
            checks++;
            if (st_a !== e.s) begin
               failures++; $display("FAIL ovl%0d_state bit%0d got=%0d exp=%0d", pass, i+1, st_a, e.s);
            end
            @(negedge clk);
         end
      end
   endtask

   // Pattern 1101: mismatch keeps a live prefix, then overlap restart at F=1
   task automatic test_kmp_fallback();
      logic [11:0] xs = 12'b111011101101;
      logic [11:0] ys = 12'b000010001001;
      int          st [12] = '{1, 2, 2, 3, 0, 1, 2, 3, 1, 2, 3, 1};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         x_b  = xs[11-i];
         en_b = 1'b1;
         ov_b = (i >= 5);
         sb.push_back('{ys[11-i], 2'(st[i]), 2'd0});
         #2;
         e = sb.pop_front();
         checks++;
         if (y_b !== e.y) begin
            failures++; $display("FAIL kmp_y bit%0d got=%b exp=%b", i+1, y_b, e.y);
         end
         @(posedge clk); #1;
         checks++;
         if (st_b !== e.s) begin
            failures++; $display("FAIL kmp_state bit%0d got=%0d exp=%0d", i+1, st_b, e.s);
         end
         @(negedge clk);
      end
      en_b = 1'b0;
   endtask

   // Async reset pulse between edges while S=3 and a completing bit is present
   task automatic test_async_reset();
      logic [2:0] xs = 3'b100;
      int         st [3] = '{1, 2, 3};
      do_reset();
      ov_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         x_a = xs[2-i]; en_a = 1'b1;
         sb.push_back('{1'b0, 2'(st[i]), 2'd0});
         #2;
         e = sb.pop_front();
         checks++;
         if (y_a !== e.y) begin failures++; $display("FAIL arst_pre_y bit%0d got=%b exp=%b", i+1, y_a, e.y); end
         @(posedge clk); #1;
         checks++;
         if (st_a !== e.s) begin failures++; $display("FAIL arst_pre_state bit%0d got=%0d exp=%0d", i+1, st_a, e.s); end
         @(negedge clk);
      end
      x_a = 1'b1; en_a = 1'b1;
      #1;
      checks++;
      if (y_a !== 1'b1) begin failures++; $display("FAIL arst_armed_y got=%b exp=1", y_a); end
      reset = 1'b1;
      #1;
      checks++;
      if (st_a !== 2'd0) begin failures++; $display("FAIL arst_state got=%0d exp=0", st_a); end
      checks++;
      if (y_a !== 1'b0) begin failures++; $display("FAIL arst_y got=%b exp=0", y_a); end
      #1;
      reset = 1'b0;
      sb.push_back('{1'b0, 2'd1, 2'd0});
      #1;
      e = sb.pop_front();
      checks++;
      if (y_a !== e.y) begin failures++; $display("FAIL arst_post_y got=%b exp=%b", y_a, e.y); end
      @(posedge clk); #1;
      checks++;
      if (st_a !== e.s) begin failures++; $display("FAIL arst_post_state got=%0d exp=%0d", st_a, e.s); end
      @(negedge clk);
   endtask

   // en=0 holds state, forces y low, ignores x (including at S=3 with x=1)
   task automatic test_enable_gating();
      logic [7:0] xs = 8'b10101011;
      logic [7:0] es = 8'b11000101;
      logic [7:0] ys = 8'b00000001;
      int         st [8] = '{1, 2, 2, 2, 2, 3, 3, 0};
      do_reset();
      ov_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         x_a = xs[7-i]; en_a = es[7-i];
         sb.push_back('{ys[7-i], 2'(st[i]), 2'd0});
         #2;
         e = sb.pop_front();
         checks++;
         if (y_a !== e.y) begin failures++; $display("FAIL en_y cyc%0d got=%b exp=%b", i+1, y_a, e.y); end
         @(posedge clk); #1;
         checks++;
         if (st_a !== e.s) begin failures++; $display("FAIL en_state cyc%0d got=%0d exp=%0d", i+1, st_a, e.s); end
         @(negedge clk);
      end
   endtask

   // overlap only matters on the match cycle
   task automatic test_overlap_sampling();
      logic [7:0] xs = 8'b10011001;
      logic [7:0] os = 8'b10100001;
      logic [7:0] ys = 8'b00010001;
      int         st [8] = '{1, 2, 3, 0, 1, 2, 3, 1};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         x_a = xs[7-i]; en_a = 1'b1; ov_a = os[7-i];
         sb.push_back('{ys[7-i], 2'(st[i]), 2'd0});
         #2;
         e = sb.pop_front();
         checks++;
         if (y_a !== e.y) begin failures++; $display("FAIL ovs_y bit%0d got=%b exp=%b", i+1, y_a, e.y); end
         @(posedge clk); #1;
         checks++;
         if (st_a !== e.s) begin failures++; $display("FAIL ovs_state bit%0d got=%0d exp=%0d", i+1, st_a, e.s); end
         @(negedge clk);
      end
   endtask

   // Five overlapping matches; 2-bit counter saturates at 3
   task automatic test_match_count();
      logic [15:0] xs = 16'b1001001001001001;
      logic [15:0] ys = 16'b0001001001001001;
      int          st [16] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
      int          m = 0;
      logic [1:0]  ec;
      do_reset();
      ov_a = 1'b1;
      for (int i = 0; i < 16; i++) begin
         x_a = xs[15-i]; en_a = 1'b1;
         if (ys[15-i]) m++;
`ifdef MEALY_MATCH_CNT_EN
         ec = (m > 3) ? 2'd3 : 2'(m);
`else
         ec = 2'd0;
`endif
         sb.push_back('{ys[15-i], 2'(st[i]), ec});
         #2;
         e = sb.pop_front();
         checks++;
         if (y_a !== e.y) begin failures++; $display("FAIL cnt_y bit%0d got=%b exp=%b", i+1, y_a, e.y); end
         @(posedge clk); #1;
         checks++;
         if (st_a !== e.s) begin failures++; $display("FAIL cnt_state bit%0d got=%0d exp=%0d", i+1, st_a, e.s); end
         checks++;
         if (mc_a !== e.c) begin failures++; $display("FAIL cnt_value bit%0d got=%0d exp=%0d", i+1, mc_a, e.c); end
         @(negedge clk);
      end
      en_a = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_overlap_modes();
      test_kmp_fallback();
      test_async_reset();
      test_enable_gating();
      test_overlap_sampling();
      test_match_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
